spi_apb_slave: RTL and testbench

- APB slave register front end for the SPI controller; sits directly downstream of the APB bus interface.
- Decodes its own select bit of the 3-bit psel, inserts one wait state per access, and returns pready/perror/prdata.
- Exposes configuration outputs and single-entry TX/RX holding buffers with a valid/ready handshake to the SPI shift core.

---
 rtl/spi_apb_slave.sv | 187 ++++++++++++++++++
 tb/tb_spi_apb_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_slave.sv
// APB register front end for the SPI controller.
// Adds one wait state to every access, commits all register side effects in
// the DONE cycle, and holds single-entry TX/RX buffers for the shift core.
module spi_apb_slave #(
  parameter int NUM_BITS   = 8,
  parameter int SEL_IDX    = 0,
  parameter int CLKDIV_RST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [NUM_BITS-1:0] paddr,
  input  logic [NUM_BITS-1:0] pwdata,
  output logic [NUM_BITS-1:0] prdata,
  output logic                pready,
  output logic                perror,
  output logic                cfg_enable,
  output logic                cfg_cpol,
  output logic                cfg_cpha,
  output logic                cfg_lsb_first,
  output logic [NUM_BITS-1:0] cfg_clkdiv,
  output logic                tx_valid,
  output logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_ready,
  input  logic                rx_valid,
  input  logic [NUM_BITS-1:0] rx_data,
  input  logic                spi_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_CLKDIV = 3'd1;
  localparam logic [2:0] A_TXDATA = 3'd2;
  localparam logic [2:0] A_RXDATA = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  state_e                state_q, state_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [NUM_BITS-1:0]   clkdiv_q, clkdiv_d;
  logic                  tx_full_q, tx_full_d;
  logic [NUM_BITS-1:0]   tx_data_q, tx_data_d;
  logic                  rx_full_q, rx_full_d;
  logic [NUM_BITS-1:0]   rx_buf_q, rx_buf_d;
  logic                  overrun_q, overrun_d;

  logic                  sel;
  logic [2:0]            addr;
  logic                  done;
  logic                  tx_pop;
  logic                  acc_err;
  logic [NUM_BITS-1:0]   rd_val;
  logic                  wr_commit;
  logic                  rd_commit;
  logic                  rx_rd;
  logic                  st_rd;

  // Only the low address bits and one psel bit are decoded.
  logic unused_bits;
  assign unused_bits = ^{paddr[NUM_BITS-1:3], psel};

  assign sel  = psel[SEL_IDX];
  assign addr = paddr[2:0];
  assign done = (state_q == S_DONE);

  // A TX byte is offered to the core only while the controller is enabled.
  assign tx_valid = tx_full_q & ctrl_q[0];
  assign tx_data  = tx_data_q;
  assign tx_pop   = tx_valid & tx_ready;

  assign cfg_enable    = ctrl_q[0];
  assign cfg_cpol      = ctrl_q[1];
  assign cfg_cpha      = ctrl_q[2];
  assign cfg_lsb_first = ctrl_q[3];
  assign cfg_clkdiv    = clkdiv_q;

  // Transfer sequencing: access phase -> one wait cycle -> one-cycle response.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (sel && penable) state_d = S_WAIT;
      S_WAIT: state_d = sel ? S_DONE : S_IDLE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address decode: error classification and read mux for the current access.
  always_comb begin
    acc_err = 1'b0;
    rd_val  = '0;
    unique case (addr)
      A_CTRL:   rd_val = NUM_BITS'(ctrl_q);
      A_CLKDIV: rd_val = clkdiv_q;
      // A pop completing this cycle frees the slot before the write lands.
      A_TXDATA: acc_err = pwrite ? (tx_full_q & ~tx_pop) : 1'b1;
      A_RXDATA: begin
        acc_err = pwrite | ~rx_full_q;
        rd_val  = rx_buf_q;
      end
      A_STATUS: begin
        acc_err = pwrite;
        rd_val  = NUM_BITS'({overrun_q, spi_busy, rx_full_q, tx_full_q});
      end
      default: acc_err = 1'b1;
    endcase
  end

  assign pready    = done;
  assign perror    = done & acc_err;
  assign prdata    = (done && !pwrite && !acc_err) ? rd_val : '0;
  assign wr_commit = done & ~acc_err & pwrite;
  assign rd_commit = done & ~acc_err & ~pwrite;
  assign rx_rd     = rd_commit & (addr == A_RXDATA);
  assign st_rd     = rd_commit & (addr == A_STATUS);

  // Register next-state: commits at DONE plus the TX/RX handshakes.
  always_comb begin
    ctrl_d    = ctrl_q;
    clkdiv_d  = clkdiv_q;
    tx_full_d = tx_full_q;
    tx_data_d = tx_data_q;
    rx_full_d = rx_full_q;
    rx_buf_d  = rx_buf_q;
    overrun_d = overrun_q;

    if (tx_pop) tx_full_d = 1'b0;

    if (wr_commit) begin
      unique case (addr)
        A_CTRL:   ctrl_d   = pwdata[3:0];
        // A divider of zero is meaningless; clamp it to the fastest legal rate.
        A_CLKDIV: clkdiv_d = (pwdata == '0) ? NUM_BITS'(1) : pwdata;
        A_TXDATA: begin
          tx_data_d = pwdata;
          tx_full_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (rx_rd) rx_full_d = 1'b0;
    if (st_rd) overrun_d = 1'b0;

    // A new byte always wins; it is an overrun only if the old one was not
    // drained in this same cycle. A new overrun beats a STATUS clear.
    if (rx_valid) begin
      rx_buf_d  = rx_data;
      rx_full_d = 1'b1;
      if (rx_full_q && !rx_rd) overrun_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset abandons any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      clkdiv_q  <= NUM_BITS'(CLKDIV_RST);
      tx_full_q <= 1'b0;
      tx_data_q <= '0;
      rx_full_q <= 1'b0;
      rx_buf_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      clkdiv_q  <= clkdiv_d;
      tx_full_q <= tx_full_d;
      tx_data_q <= tx_data_d;
      rx_full_q <= rx_full_d;
      rx_buf_q  <= rx_buf_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_apb_slave.sv
// Self-checking bench for spi_apb_slave: directed register-map steps followed
// by randomized accesses, compared against a register-level reference model.
module tb_spi_apb_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       perror;
  logic       cfg_enable, cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [7:0] cfg_clkdiv;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       spi_busy;

  always #5 clk = ~clk;

  spi_apb_slave #(.NUM_BITS(8), .SEL_IDX(0), .CLKDIV_RST(4)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .perror(perror), .cfg_enable(cfg_enable), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .cfg_clkdiv(cfg_clkdiv), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .spi_busy(spi_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the architectural register contents.
  logic [3:0] m_ctrl;
  logic [7:0] m_clkdiv, m_tx_data, m_rx_buf;
  bit         m_tx_full, m_rx_full, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 4'h0; m_clkdiv = 8'd4; m_tx_data = 8'h00; m_rx_buf = 8'h00;
    m_tx_full = 0; m_rx_full = 0; m_ovr = 0;
  endtask

  // Register-map rules for one completed access; updates the model.
  task automatic model_txn(input bit wr, input logic [2:0] a, input logic [7:0] wd,
                           input bit busy, input bit rx_ev, input logic [7:0] rx_d,
                           input bit pop_ev, output bit e_err, output logic [7:0] e_rd);
    bit pop, drained;
    pop   = pop_ev && m_tx_full && m_ctrl[0];
    e_err = 1'b0;
    e_rd  = 8'h00;
    case (a)
      3'd0: if (!wr) e_rd = {4'h0, m_ctrl};
      3'd1: if (!wr) e_rd = m_clkdiv;
      3'd2: e_err = wr ? (m_tx_full && !pop) : 1'b1;
      3'd3: begin e_err = wr || !m_rx_full; if (!e_err) e_rd = m_rx_buf; end
      3'd4: begin e_err = wr; if (!wr) e_rd = {4'h0, m_ovr, busy, m_rx_full, m_tx_full}; end
      default: e_err = 1'b1;
    endcase
    drained = !wr && !e_err && a == 3'd3;
    if (pop) m_tx_full = 0;
    if (wr && !e_err) begin
      if (a == 3'd0) m_ctrl = wd[3:0];
      if (a == 3'd1) m_clkdiv = (wd == 8'h00) ? 8'h01 : wd;
      if (a == 3'd2) begin m_tx_data = wd; m_tx_full = 1; end
    end
    if (drained) m_rx_full = 0;
    if (!wr && a == 3'd4) m_ovr = 0;
    if (rx_ev) begin
      if (m_rx_full) m_ovr = 1;
      m_rx_full = 1;
      m_rx_buf  = rx_d;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cfg"}, {cfg_lsb_first, cfg_cpha, cfg_cpol, cfg_enable}, m_ctrl);
    check({tag, ".clkdiv"}, cfg_clkdiv, m_clkdiv);
    check({tag, ".tx_valid"}, tx_valid, m_tx_full && m_ctrl[0]);
    if (m_tx_full) check({tag, ".tx_data"}, tx_data, m_tx_data);
  endtask

  // One APB access; optional rx_valid / tx_ready events in its DONE cycle.
  task automatic txn(input string tag, input bit wr, input logic [7:0] addr,
                     input logic [7:0] wd, input bit busy, input bit rx_ev,
                     input logic [7:0] rx_d, input bit pop_ev,
                     output logic [7:0] rd, output bit er);
    bit         e_err;
    logic [7:0] e_rd;
    @(negedge clk);
    psel = 3'b001; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; spi_busy = busy;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    check({tag, ".wait"}, pready, 1'b0);
    @(negedge clk);
    rx_valid = rx_ev; rx_data = rx_d; tx_ready = pop_ev;
    #1;
    check({tag, ".ready"}, pready, 1'b1);
    model_txn(wr, addr[2:0], wd, busy, rx_ev, rx_d, pop_ev, e_err, e_rd);
    check({tag, ".perror"}, perror, e_err);
    check({tag, ".prdata"}, prdata, e_rd);
    rd = prdata;
    er = perror;
    psel = 3'b000; penable = 0;
    @(negedge clk);
    rx_valid = 0; tx_ready = 0;
    check({tag, ".one_cycle"}, pready, 1'b0);
    check_state(tag);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1; rx_data = d;
    if (m_rx_full) m_ovr = 1;
    m_rx_full = 1; m_rx_buf = d;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic tx_pulse();
    @(negedge clk);
    tx_ready = 1;
    if (m_tx_full && m_ctrl[0]) m_tx_full = 0;
    @(negedge clk);
    tx_ready = 0;
    check_state("tx_pulse");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit         er;
    bit         seen;

    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; spi_busy = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.pready", pready, 1'b0);
    check("rst.perror", perror, 1'b0);
    check("rst.prdata", prdata, 8'h00);
    check_state("rst");
    rst = 0;

    // Reset values through the bus.
    txn("rd_ctrl", 0, 8'd0, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.ctrl_rst", rd, 8'h00);
    txn("rd_clkdiv", 0, 8'd1, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.clkdiv_rst", rd, 8'h04);
    txn("rd_status", 0, 8'd4, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.status_rst", rd, 8'h00);

    // Config writes, CLKDIV zero clamp.
    txn("wr_ctrl", 1, 8'd0, 8'h0F, 0, 0, 8'h00, 0, rd, er);
    txn("wr_clkdiv", 1, 8'd1, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.cfg_clkdiv", cfg_clkdiv, 8'h01);
    check("tp.cfg_bits", {cfg_lsb_first, cfg_cpha, cfg_cpol, cfg_enable}, 4'hF);
    txn("rd_ctrl2", 0, 8'd0, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.ctrl_rb", rd, 8'h0F);
    txn("rd_clkdiv2", 0, 8'd1, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.clkdiv_rb", rd, 8'h01);

    // TX buffer: load, full-discard, pop.
    txn("wr_tx", 1, 8'd2, 8'hA5, 0, 0, 8'h00, 0, rd, er);
    check("tp.tx_valid", tx_valid, 1'b1);
    check("tp.tx_data", tx_data, 8'hA5);
    txn("wr_tx_full", 1, 8'd2, 8'h3C, 0, 0, 8'h00, 0, rd, er);
    check("tp.tx_full_err", er, 1'b1);
    check("tp.tx_data_kept", tx_data, 8'hA5);
    tx_pulse();
    check("tp.tx_popped", tx_valid, 1'b0);
    txn("rd_status_tx", 0, 8'd4, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.status_tx", rd[0], 1'b0);

    // RX buffer: overrun, read, clear, empty read.
    rx_pulse(8'h55);
    rx_pulse(8'h66);
    txn("rd_status_ovr", 0, 8'd4, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.status_ovr", rd, 8'h0A);
    txn("rd_rx", 0, 8'd3, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.rx_data", rd, 8'h66);
    txn("rd_status_clr", 0, 8'd4, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.status_clr", rd, 8'h00);
    txn("rd_rx_empty", 0, 8'd3, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.rx_empty_err", er, 1'b1);
    check("tp.rx_empty_data", rd, 8'h00);

    // Error accesses.
    txn("rd_txdata", 0, 8'd2, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.rd_tx_err", er, 1'b1);
    txn("wr_status", 1, 8'd4, 8'hFF, 0, 0, 8'h00, 0, rd, er);
    check("tp.wr_status_err", er, 1'b1);
    txn("wr_unmapped", 1, 8'd6, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.unmapped_err", er, 1'b1);
    txn("rd_unmapped", 0, 8'd6, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.unmapped_rd", {er, rd}, 9'h100);

    // Another slave's select: no response, no effect.
    @(negedge clk);
    psel = 3'b010; penable = 0; pwrite = 1; paddr = 8'd0; pwdata = 8'h05;
    @(negedge clk);
    penable = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= pready;
    end
    check("other_sel.pready", seen, 1'b0);
    psel = 0; penable = 0;
    @(negedge clk);
    check_state("other_sel");

    // Same-cycle boundaries.
    rx_pulse(8'h11);
    txn("rx_rd_and_load", 0, 8'd3, 8'h00, 0, 1, 8'h22, 0, rd, er);
    check("tp.rx_old_byte", rd, 8'h11);
    txn("status_no_ovr", 0, 8'd4, 8'h00, 1, 0, 8'h00, 0, rd, er);
    check("tp.status_busy", rd, 8'h06);
    txn("status_with_ovr", 0, 8'd4, 8'h00, 0, 1, 8'h33, 0, rd, er);
    check("tp.status_pre_ovr", rd, 8'h02);
    txn("status_ovr_kept", 0, 8'd4, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.status_ovr_kept", rd, 8'h0A);
    txn("wr_tx_a", 1, 8'd2, 8'h77, 0, 0, 8'h00, 0, rd, er);
    txn("wr_tx_pop", 1, 8'd2, 8'h88, 0, 0, 8'h00, 1, rd, er);
    check("tp.tx_pop_write_ok", er, 1'b0);
    check("tp.tx_pop_write_data", tx_data, 8'h88);

    // Reset during the wait state of a CTRL write.
    txn("clr_ctrl_prep", 1, 8'd0, 8'h00, 0, 0, 8'h00, 0, rd, er);
    @(negedge clk);
    psel = 3'b001; penable = 0; pwrite = 1; paddr = 8'd0; pwdata = 8'h0F;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst.pready", pready, 1'b0);
    rst = 0; psel = 0; penable = 0;
    model_reset();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen |= pready;
    end
    check("midrst.no_ready", seen, 1'b0);
    check_state("midrst");
    txn("midrst_rd_ctrl", 0, 8'd0, 8'h00, 0, 0, 8'h00, 0, rd, er);
    check("tp.midrst_ctrl", rd, 8'h00);

    // Randomized accesses against the model.
    for (int i = 0; i < 60; i++) begin
      bit         wr, busy, rx_ev, pop_ev;
      logic [7:0] a, wd;
      wr     = 1'($urandom_range(0, 1));
      a      = 8'($urandom_range(0, 7));
      wd     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      busy   = 1'($urandom_range(0, 1));
      rx_ev  = ($urandom_range(0, 3) == 0);
      pop_ev = ($urandom_range(0, 3) == 0);
      txn($sformatf("rnd%0d", i), wr, a, wd, busy, rx_ev, 8'($urandom), pop_ev, rd, er);
      if ($urandom_range(0, 4) == 0) rx_pulse(8'($urandom));
      if ($urandom_range(0, 3) == 0) tx_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
